// File: rtl/instr_fetch_buffer.sv
// PC-driven fetch stage: issues in-order imem reads under a credit limit,
// buffers responses in a small FIFO and feeds one instruction per cycle to decode.
module instr_fetch_buffer #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 8,
    parameter int PC_W    = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [PC_W-1:0]        flush_pc,
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_W-1:0]     imem_rdata,
    output logic [INSTR_W-1:0]     if_id_reg,
    output logic                   if_id_valid,
    output logic [$clog2(DEPTH):0] buf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic [INSTR_W-1:0] if_id_reg_q, if_id_reg_d;
    logic               if_id_valid_q, if_id_valid_d;

    logic [CNT_W:0] credit_used;
    logic           accept;
    logic           push;
    logic           pop;

    // Buffered plus in-flight reads never exceed DEPTH, so a push always has room.
    assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req    = resetn & ~flush & (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr   = pc_q;
    assign accept      = imem_req & imem_ready;
    assign push        = imem_rvalid & (discard_q == '0) & ~flush;
    assign pop         = ~flush & ~stall & (count_q != '0);

    assign if_id_reg   = if_id_reg_q;
    assign if_id_valid = if_id_valid_q;
    assign buf_count   = count_q;

    always_comb begin
        pc_d          = pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outst_d       = outst_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
        discard_d     = discard_q;
        if_id_reg_d   = if_id_reg_q;
        if_id_valid_d = if_id_valid_q;

        if (accept) pc_d = pc_q + PC_W'(1);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (imem_rvalid && discard_q != '0) begin
            discard_d = discard_q - CNT_W'(1);
        end

        if (!stall) begin
            if_id_reg_d   = pop ? mem_q[rd_ptr_q] : '0;
            if_id_valid_d = pop;
        end

        // Every read still outstanding after this cycle belongs to the old stream.
        if (flush) begin
            pc_d          = flush_pc;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            discard_d     = outst_d;
            if_id_reg_d   = '0;
            if_id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outst_q       <= '0;
            discard_q     <= '0;
            if_id_reg_q   <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outst_q       <= outst_d;
            discard_q     <= discard_d;
            if_id_reg_q   <= if_id_reg_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            assert (count_q != CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: a memory model queues expected
// instructions on every accepted read; a monitor checks what decode receives.
module tb_instr_fetch_buffer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] flush_pc = 8'h00;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ready = 1'b0;
    logic       imem_rvalid = 1'b0;
    logic [7:0] imem_rdata = 8'h00;
    logic [7:0] if_id_reg;
    logic       if_id_valid;
    logic [2:0] buf_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        int         due;
        logic [7:0] data;
    } rsp_t;

    rsp_t       mq[$];
    logic [7:0] exp_q[$];

    instr_fetch_buffer #(.DEPTH(4), .INSTR_W(8), .PC_W(8)) dut (
        .clk(clk),
        .resetn(resetn),
        .stall(stall),
        .flush(flush),
        .flush_pc(flush_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_id_reg(if_id_reg),
        .if_id_valid(if_id_valid),
        .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One cycle: drive inputs at negedge, answer due reads, log accepts.
    task automatic step(input bit rst, input bit st, input bit fl,
                        input bit rdy);
        rsp_t r;
        @(negedge clk);
        cyc++;
        resetn     = rst;
        stall      = st;
        flush      = fl;
        imem_ready = rdy;
        if (!rst) begin
            mq.delete();
            exp_q.delete();
        end
        if (fl) exp_q.delete();
        if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
            r           = mq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = r.data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 8'h00;
        end
        #1;
        if (imem_req && imem_ready) begin
            mq.push_back('{cyc + lat, imem_addr + 8'h10});
            exp_q.push_back(imem_addr + 8'h10);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            step(1, 0, 0, 0);
        end
        step(1, 0, 0, 0);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: compares each newly presented instruction with the scoreboard.
    initial begin
        logic       s_rst, s_st, s_fl;
        logic [7:0] prev_reg;
        logic       prev_v;
        logic [7:0] e;
        prev_reg = 8'h00;
        prev_v   = 1'b0;
        forever begin
            @(posedge clk);
            s_rst = resetn;
            s_st  = stall;
            s_fl  = flush;
            #2;
            if (!s_rst || s_fl) begin
                check("clr_valid", if_id_valid, 0);
                check("clr_reg", if_id_reg, 0);
            end else if (s_st) begin
                check("hold_valid", if_id_valid, prev_v);
                check("hold_reg", if_id_reg, prev_reg);
            end else if (if_id_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got %0h expected none",
                             if_id_reg);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", if_id_reg, e);
                end
            end else begin
                check("bubble_reg", if_id_reg, 0);
            end
            prev_reg = if_id_reg;
            prev_v   = if_id_valid;
        end
    end

    initial begin
        logic [7:0] t4 [4];
        t4[0] = 8'hFE;
        t4[1] = 8'hFF;
        t4[2] = 8'h00;
        t4[3] = 8'h01;

        // Reset, 1-cycle memory, streaming
        lat = 1;
        step(0, 0, 0, 0);
        check("req_in_reset", imem_req, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        check("rst_count", buf_count, 0);
        check("rst_valid", if_id_valid, 0);
        check("rst_reg", if_id_reg, 0);
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 8'h00);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check("t1_i0", if_id_reg, 8'h10);
        check("t1_v0", if_id_valid, 1);
        step(1, 0, 0, 1);
        check("t1_i1", if_id_reg, 8'h11);

        // Stall for 5 cycles mid-stream
        step(1, 1, 0, 1);
        check("t1_i2", if_id_reg, 8'h12);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        check("t2_req_off", imem_req, 0);
        check("t2_cnt3", buf_count, 3);
        step(1, 1, 0, 1);
        check("t2_cnt4", buf_count, 4);
        check("t2_req_off2", imem_req, 0);
        check("t2_frozen", if_id_reg, 8'h12);
        step(1, 1, 0, 1);
        step(1, 0, 0, 1);
        check("t2_req_full", imem_req, 0);
        check("t2_frozen2", if_id_reg, 8'h12);
        step(1, 0, 0, 1);
        check("t2_rel", if_id_reg, 8'h13);
        check("t2_cnt_rel", buf_count, 3);
        check("t2_req_on", imem_req, 1);
        check("t2_addr", imem_addr, 8'h07);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        drain("t2_drain");

        // Latency 3, flush with two reads outstanding
        step(0, 0, 0, 0);
        lat = 3;
        flush_pc = 8'h40;
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 1, 1);
        check("t3_req_flush", imem_req, 0);
        step(1, 0, 0, 1);
        check("t3_req", imem_req, 1);
        check("t3_addr", imem_addr, 8'h40);
        check("t3_valid0", if_id_valid, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check("t3_first", if_id_reg, 8'h50);
        check("t3_firstv", if_id_valid, 1);
        drain("t3_drain");

        // PC wrap
        lat = 1;
        flush_pc = 8'hFE;
        step(1, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1);
            check("t4_req", imem_req, 1);
            check("t4_addr", imem_addr, t4[i]);
        end
        drain("t4_drain");

        // Flush and stall together with a full FIFO
        for (int i = 0; i < 6; i++) step(1, 1, 0, 1);
        check("t5_full", buf_count, 4);
        flush_pc = 8'h80;
        step(1, 1, 1, 1);
        step(1, 1, 0, 1);
        check("t5_cnt", buf_count, 0);
        check("t5_valid", if_id_valid, 0);
        check("t5_addr", imem_addr, 8'h80);
        check("t5_req", imem_req, 1);
        drain("t5_drain");

        // Reset pulse with reads outstanding
        lat = 3;
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t6_req_rst", imem_req, 0);
        step(1, 0, 0, 0);
        check("t6_cnt", buf_count, 0);
        check("t6_valid", if_id_valid, 0);
        check("t6_reg", if_id_reg, 0);
        check("t6_addr", imem_addr, 8'h00);
        check("t6_req", imem_req, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
